// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush and a saturating stall counter.
// Define PIPE_SKID_EN to add a skid entry and register in_ready.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_accept;
    logic              w_emit;

    assign w_emit   = r_valid && out_ready;
    assign w_accept = in_valid && in_ready && !flush;

`ifdef PIPE_SKID_EN
    logic              r_sk_valid;
    logic [DATA_W-1:0] r_sk_data;

    // in_ready depends only on state (plus flush), never on out_ready
    assign in_ready = !r_sk_valid || flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_sk_valid <= 1'b0;
            r_sk_data  <= '0;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_sk_valid <= 1'b0;
            r_sk_data  <= '0;
        end else if (w_emit && r_sk_valid) begin
            // in_ready is low while the skid is full, so no accept can collide here
            r_data     <= r_sk_data;
            r_sk_valid <= 1'b0;
        end else if (w_accept && (!r_valid || w_emit)) begin
            r_valid <= 1'b1;
            r_data  <= in_data;
        end else if (w_accept) begin
            r_sk_valid <= 1'b1;
            r_sk_data  <= in_data;
        end else if (w_emit) begin
            r_valid <= 1'b0;
        end
    end
`else
    assign in_ready = !r_valid || out_ready || flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= in_data;
        end else if (w_emit) begin
            r_valid <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (r_valid && !out_ready && r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue model checked every cycle plus directed literal checks.
module tb_pipe_stage_reg;

    localparam int DATA_W = 70;
    localparam int CNT_W  = 4;
`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam int CAP = SKID ? 2 : 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              cnt_clr = 1'b0;
    logic [CNT_W-1:0]  stall_cnt;

    int n_chk = 0;
    int n_err = 0;

    pipe_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cnt_clr(cnt_clr), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the stage is a FIFO of capacity CAP; out_data shows the head,
    // else the last shown value (zero after reset/flush).
    logic [DATA_W-1:0] mq[$];
    logic [DATA_W-1:0] m_last;
    int                m_cnt;

    function automatic logic exp_ready();
        return flush || (mq.size() < CAP) || (!SKID && out_ready);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_last = '0;
            m_cnt  = 0;
        end else begin
            logic v, acc, emit;
            v    = mq.size() > 0;
            acc  = in_valid && exp_ready() && !flush;
            emit = v && out_ready;
            if (cnt_clr) m_cnt = 0;
            else if (v && !out_ready && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (flush) begin
                mq.delete();
                m_last = '0;
            end else begin
                if (emit) void'(mq.pop_front());
                if (acc) mq.push_back(in_data);
                if (mq.size() > 0) m_last = mq[0];
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("model out_valid", out_valid, mq.size() > 0);
            chk("model out_data", out_data, m_last);
            chk("model stall_cnt", stall_cnt, m_cnt);
            chk("model in_ready", in_ready, exp_ready());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [95:0] r;
        #12;
        chk("reset out_valid", out_valid, 0);
        chk("reset out_data", out_data, 0);
        chk("reset stall_cnt", stall_cnt, 0);
        rst = 1'b1;
        #1;
        chk("post-reset in_ready", in_ready, 1);

        // stream with no back-pressure
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data = 'h11; step(); chk("stream 11", out_data, 'h11); chk("stream v", out_valid, 1);
        in_data = 'h22; step(); chk("stream 22", out_data, 'h22); chk("stream v", out_valid, 1);
        in_data = 'h33; step(); chk("stream 33", out_data, 'h33); chk("stream v", out_valid, 1);
        in_valid = 1'b0; step();
        chk("stream drain v", out_valid, 0);
        chk("stream hold data", out_data, 'h33);
        chk("stream stall_cnt", stall_cnt, 0);

        // back-pressure: hold AA for 5 cycles, BB offered behind it
        out_ready = 1'b0; in_valid = 1'b1; in_data = 'hAA; step();
        chk("hold load", out_data, 'hAA);
        in_data = 'hBB;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold data", out_data, 'hAA);
            chk("hold in_ready", in_ready, 0);
        end
        chk("hold stall_cnt", stall_cnt, 5);
        if (SKID) in_valid = 1'b0;
        out_ready = 1'b1; step();
        in_valid = 1'b0;
        chk("release BB", out_data, 'hBB);
        chk("release v", out_valid, 1);
        chk("release in_ready", in_ready, 1);
        step();
        chk("release drain", out_valid, 0);

        // flush with a held payload and a concurrent input
        out_ready = 1'b0; in_valid = 1'b1; in_data = 'h44; step();
        chk("flush pre v", out_valid, 1);
        flush = 1'b1; in_data = 'h55; #1;
        chk("flush in_ready", in_ready, 1);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush v", out_valid, 0);
        chk("flush data", out_data, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush 55 dropped", out_valid, 0);
        end

        // counter saturation and clear
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        chk("cnt cleared", stall_cnt, 0);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 'h66; step();
        in_valid = 1'b0;
        repeat (20) step();
        chk("cnt saturate", stall_cnt, 15);
        cnt_clr = 1'b1; step();
        chk("cnt_clr priority", stall_cnt, 0);
        cnt_clr = 1'b0; step();
        chk("cnt restart", stall_cnt, 1);

        // asynchronous reset while stalled (skid full when present)
        in_valid = 1'b1; in_data = 'h77; step();
        in_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("midreset v", out_valid, 0);
        chk("midreset data", out_data, 0);
        chk("midreset cnt", stall_cnt, 0);
        #1 rst = 1'b1;
        chk("midreset in_ready", in_ready, 1);
        in_valid = 1'b1; in_data = 'h88; out_ready = 1'b1; step();
        in_valid = 1'b0;
        chk("after reset 88", out_data, 'h88);
        chk("after reset v", out_valid, 1);
        step();
        chk("after reset drain", out_valid, 0);

        // random traffic against the model
        for (int i = 0; i < 10000; i++) begin
            r = {$urandom, $urandom, $urandom};
            in_data   = r[DATA_W-1:0];
            in_valid  = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 15) == 0;
            cnt_clr   = $urandom_range(0, 63) == 0;
            step();
        end
        in_valid = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
